// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   state_e           : MEM stage access FSM states
//   Funct3* constants : load/store width encodings carried in exe_funct3
//   is_misaligned()   : natural-alignment test for a load/store width and byte lane
package mem_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StDone
   } state_e;

   localparam logic [2:0] Funct3Lb  = 3'b000;
   localparam logic [2:0] Funct3Lh  = 3'b001;
   localparam logic [2:0] Funct3Lw  = 3'b010;
   localparam logic [2:0] Funct3Lbu = 3'b100;
   localparam logic [2:0] Funct3Lhu = 3'b101;
   localparam logic [2:0] Funct3Sb  = 3'b000;
   localparam logic [2:0] Funct3Sh  = 3'b001;
   localparam logic [2:0] Funct3Sw  = 3'b010;

   // funct3[1:0] encodes the access width for both loads and stores.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
      unique case (funct3[1:0])
         2'b01:   return lane[0];
         2'b10:   return lane != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the MEM stage.
//   funct3   : access width / signedness
//   lane     : byte address within the word (address bits [1:0])
//   st_data  : raw store operand (rs2)
//   ld_word  : full word returned by data memory
//   st_we    : per-byte write strobe for a store
//   st_wdata : store data replicated across the word
//   ld_data  : extracted and extended load result
// A halfword whose lane is odd falls back to lane 0; with the misalignment
// check enabled such accesses never reach memory, so the fallback is harmless.
module lsu_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_word,
   output logic [3:0]  st_we,
   output logic [31:0] st_wdata,
   output logic [31:0] ld_data
);

   logic [1:0]  half_lane;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign half_lane = lane[0] ? 2'b00 : lane;

   always_comb begin
      st_we    = 4'b1111;
      st_wdata = st_data;
      unique case (funct3)
         Funct3Sb: begin
            st_we    = 4'b0001 << lane;
            st_wdata = {4{st_data[7:0]}};
         end
         Funct3Sh: begin
            st_we    = 4'b0011 << half_lane;
            st_wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = ld_word[7:0];
      unique case (lane)
         2'd0: ld_byte = ld_word[7:0];
         2'd1: ld_byte = ld_word[15:8];
         2'd2: ld_byte = ld_word[23:16];
         2'd3: ld_byte = ld_word[31:24];
         default: ;
      endcase
   end

   assign ld_half = half_lane[1] ? ld_word[31:16] : ld_word[15:0];

   always_comb begin
      ld_data = ld_word;
      unique case (funct3)
         Funct3Lb:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         Funct3Lbu: ld_data = {24'h0, ld_byte};
         Funct3Lh:  ld_data = {{16{ld_half[15]}}, ld_half};
         Funct3Lhu: ld_data = {16'h0, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a req/ack data-memory port and the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_CHK_EN (misaligned accesses are dropped and flagged).
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   exe_*                         : EXE/MEM register contents (held by upstream while mem_stall)
//   dm_req/dm_we/dm_addr/dm_wdata : registered data-memory request (dm_we=0 means read)
//   dm_rdata/dm_ack               : data-memory response
//   mem_stall                     : freeze IF/ID/EXE and hold EXE/MEM
//   forward_memrddata             : combinational forwarding value to EXE
//   wb_*                          : MEM/WB register outputs
//   misalign_err                  : one-cycle pulse on a dropped misaligned access
// A memory instruction occupies IDLE (stall) -> ACCESS (stall until ack) -> DONE (retire).
module mem_stage
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] exe_pctoreg,
   input  logic [31:0] exe_aluout,
   input  logic [31:0] exe_rs2data,
   input  logic [4:0]  exe_rdaddr,
   input  logic [2:0]  exe_funct3,
   input  logic        exe_rdsrc,
   input  logic        exe_memread,
   input  logic        exe_memwrite,
   input  logic        exe_memtoreg,
   input  logic        exe_regwrite,
   output logic        dm_req,
   output logic [3:0]  dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        mem_stall,
   output logic [31:0] forward_memrddata,
   output logic [31:0] wb_rddata,
   output logic [31:0] wb_lddata,
   output logic [4:0]  wb_rdaddr,
   output logic        wb_memtoreg,
   output logic        wb_regwrite,
   output logic        misalign_err
);

   state_e      state_q, state_d;
   logic        dm_req_q, dm_req_d;
   logic [3:0]  dm_we_q, dm_we_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic [31:0] dm_wdata_q, dm_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] wb_rddata_q, wb_rddata_d;
   logic [31:0] wb_lddata_q, wb_lddata_d;
   logic [4:0]  wb_rdaddr_q, wb_rdaddr_d;
   logic        wb_memtoreg_q, wb_memtoreg_d;
   logic        wb_regwrite_q, wb_regwrite_d;

   logic        mem_op;
   logic        misalign;
   logic [3:0]  st_we;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   assign forward_memrddata = exe_rdsrc ? exe_pctoreg : exe_aluout;
   assign mem_op            = exe_memread | exe_memwrite;

`ifdef MEM_MISALIGN_CHK_EN
   assign misalign = mem_op & is_misaligned(exe_funct3, exe_aluout[1:0]);
`else
   assign misalign = 1'b0;
`endif

   lsu_align u_lsu_align (
      .funct3   (exe_funct3),
      .lane     (exe_aluout[1:0]),
      .st_data  (exe_rs2data),
      .ld_word  (rdata_q),
      .st_we    (st_we),
      .st_wdata (st_wdata),
      .ld_data  (ld_data)
   );

   // Access FSM and data-memory request.
   always_comb begin
      state_d    = state_q;
      mem_stall  = 1'b0;
      dm_req_d   = dm_req_q;
      dm_we_d    = dm_we_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      rdata_d    = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (mem_op && !misalign) begin
               mem_stall  = 1'b1;
               state_d    = StAccess;
               dm_req_d   = 1'b1;
               dm_addr_d  = {exe_aluout[31:2], 2'b00};
               dm_we_d    = exe_memwrite ? st_we : 4'b0000;
               dm_wdata_d = exe_memwrite ? st_wdata : 32'h0;
            end
         end
         StAccess: begin
            mem_stall = 1'b1;
            if (dm_ack) begin
               rdata_d  = dm_rdata;
               dm_req_d = 1'b0;
               state_d  = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d  = StIdle;
            dm_req_d = 1'b0;
         end
      endcase
   end

   // MEM/WB register: bubble while stalled, otherwise retire the EXE/MEM instruction.
   always_comb begin
      wb_rddata_d   = 32'h0;
      wb_lddata_d   = 32'h0;
      wb_rdaddr_d   = 5'd0;
      wb_memtoreg_d = 1'b0;
      wb_regwrite_d = 1'b0;
      if (!mem_stall) begin
         wb_rddata_d   = forward_memrddata;
         wb_rdaddr_d   = exe_rdaddr;
         wb_memtoreg_d = exe_memtoreg;
         wb_regwrite_d = exe_regwrite & ~misalign;
         if (state_q == StDone && exe_memread) begin
            wb_lddata_d = ld_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         dm_req_q      <= 1'b0;
         dm_we_q       <= 4'b0000;
         dm_addr_q     <= 32'h0;
         dm_wdata_q    <= 32'h0;
         rdata_q       <= 32'h0;
         wb_rddata_q   <= 32'h0;
         wb_lddata_q   <= 32'h0;
         wb_rdaddr_q   <= 5'd0;
         wb_memtoreg_q <= 1'b0;
         wb_regwrite_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         dm_req_q      <= dm_req_d;
         dm_we_q       <= dm_we_d;
         dm_addr_q     <= dm_addr_d;
         dm_wdata_q    <= dm_wdata_d;
         rdata_q       <= rdata_d;
         wb_rddata_q   <= wb_rddata_d;
         wb_lddata_q   <= wb_lddata_d;
         wb_rdaddr_q   <= wb_rdaddr_d;
         wb_memtoreg_q <= wb_memtoreg_d;
         wb_regwrite_q <= wb_regwrite_d;
      end
   end

`ifdef MEM_MISALIGN_CHK_EN
   logic misalign_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign;
      end
   end

   assign misalign_err = misalign_q;
`else
   assign misalign_err = 1'b0;
`endif

   assign dm_req      = dm_req_q;
   assign dm_we       = dm_we_q;
   assign dm_addr     = dm_addr_q;
   assign dm_wdata    = dm_wdata_q;
   assign wb_rddata   = wb_rddata_q;
   assign wb_lddata   = wb_lddata_q;
   assign wb_rdaddr   = wb_rdaddr_q;
   assign wb_memtoreg = wb_memtoreg_q;
   assign wb_regwrite = wb_regwrite_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic [31:0] exe_pctoreg, exe_aluout, exe_rs2data;
   logic [4:0]  exe_rdaddr;
   logic [2:0]  exe_funct3;
   logic        exe_rdsrc, exe_memread, exe_memwrite, exe_memtoreg, exe_regwrite;
   logic        dm_req;
   logic [3:0]  dm_we;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_ack;
   logic        mem_stall;
   logic [31:0] forward_memrddata;
   logic [31:0] wb_rddata, wb_lddata;
   logic [4:0]  wb_rdaddr;
   logic        wb_memtoreg, wb_regwrite, misalign_err;

   int checks   = 0;
   int failures = 0;

   int          stall_cycles;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_we;

   mem_stage dut (
      .clk               (clk),
      .rst               (rst),
      .exe_pctoreg       (exe_pctoreg),
      .exe_aluout        (exe_aluout),
      .exe_rs2data       (exe_rs2data),
      .exe_rdaddr        (exe_rdaddr),
      .exe_funct3        (exe_funct3),
      .exe_rdsrc         (exe_rdsrc),
      .exe_memread       (exe_memread),
      .exe_memwrite      (exe_memwrite),
      .exe_memtoreg      (exe_memtoreg),
      .exe_regwrite      (exe_regwrite),
      .dm_req            (dm_req),
      .dm_we             (dm_we),
      .dm_addr           (dm_addr),
      .dm_wdata          (dm_wdata),
      .dm_rdata          (dm_rdata),
      .dm_ack            (dm_ack),
      .mem_stall         (mem_stall),
      .forward_memrddata (forward_memrddata),
      .wb_rddata         (wb_rddata),
      .wb_lddata         (wb_lddata),
      .wb_rdaddr         (wb_rdaddr),
      .wb_memtoreg       (wb_memtoreg),
      .wb_regwrite       (wb_regwrite),
      .misalign_err      (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic set_exe(input logic rdsrc, input logic [31:0] pctoreg, input logic [31:0] aluout,
                          input logic [31:0] rs2, input logic [4:0] rdaddr,
                          input logic [2:0] funct3, input logic memread, input logic memwrite,
                          input logic memtoreg, input logic regwrite);
      exe_rdsrc    = rdsrc;
      exe_pctoreg  = pctoreg;
      exe_aluout   = aluout;
      exe_rs2data  = rs2;
      exe_rdaddr   = rdaddr;
      exe_funct3   = funct3;
      exe_memread  = memread;
      exe_memwrite = memwrite;
      exe_memtoreg = memtoreg;
      exe_regwrite = regwrite;
   endtask

   // Called right after a rising edge with a memory instruction on the EXE inputs.
   // Acks in the ack_at-th request cycle; returns at the negedge of the DONE cycle.
   task automatic do_access(input int ack_at, input logic [31:0] rdata);
      int req_cycles = 0;
      bit done = 0;
      stall_cycles = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!mem_stall) begin
            done = 1;
            break;
         end
         stall_cycles++;
         if (c > 0) check_eq("bubble_regwrite", {31'h0, wb_regwrite}, 32'h0);
         if (dm_req) begin
            req_cycles++;
            if (req_cycles == 1) begin
               cap_addr  = dm_addr;
               cap_we    = dm_we;
               cap_wdata = dm_wdata;
            end
            if (req_cycles == ack_at) begin
               dm_ack   = 1'b1;
               dm_rdata = rdata;
            end
         end
         @(posedge clk);
         #1 dm_ack = 1'b0;
      end
      check_eq("access_done", {31'h0, done}, 32'h1);
      check_eq("req_low_in_done", {31'h0, dm_req}, 32'h0);
   endtask

   initial begin
      rst      = 1'b0;
      dm_ack   = 1'b0;
      dm_rdata = 32'h0;
      set_exe(0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_dm_req", {31'h0, dm_req}, 32'h0);
      check_eq("rst_dm_we", {28'h0, dm_we}, 32'h0);
      check_eq("rst_dm_addr", dm_addr, 32'h0);
      check_eq("rst_wb_regwrite", {31'h0, wb_regwrite}, 32'h0);
      check_eq("rst_mem_stall", {31'h0, mem_stall}, 32'h0);
      check_eq("rst_misalign", {31'h0, misalign_err}, 32'h0);

      // ADD x7 = 0x55, retires in one cycle without stall
      @(posedge clk);
      #1 rst = 1'b1;
      set_exe(0, 32'h0, 32'h55, 32'h0, 5'd7, 3'b000, 0, 0, 0, 1);
      @(negedge clk);
      check_eq("add_forward", forward_memrddata, 32'h55);
      check_eq("add_no_stall", {31'h0, mem_stall}, 32'h0);
      @(posedge clk);
      #1;
      check_eq("add_wb_rddata", wb_rddata, 32'h55);
      check_eq("add_wb_rdaddr", {27'h0, wb_rdaddr}, 32'd7);
      check_eq("add_wb_regwrite", {31'h0, wb_regwrite}, 32'h1);

      // LW x3 from 0x400, ack in first request cycle
      set_exe(0, 32'h0, 32'h400, 32'h0, 5'd3, 3'b010, 1, 0, 1, 1);
      @(negedge clk);
      check_eq("lw_stall_in_idle", {31'h0, mem_stall}, 32'h1);
      check_eq("lw_no_req_in_idle", {31'h0, dm_req}, 32'h0);
      @(posedge clk);
      #1 do_access(1, 32'h1234_5678);
      check_eq("lw_stall_cycles", stall_cycles, 32'd1);
      check_eq("lw_addr", cap_addr, 32'h400);
      check_eq("lw_we", {28'h0, cap_we}, 32'h0);
      @(posedge clk);
      #1;
      check_eq("lw_lddata", wb_lddata, 32'h1234_5678);
      check_eq("lw_rddata", wb_rddata, 32'h400);
      check_eq("lw_rdaddr", {27'h0, wb_rdaddr}, 32'd3);
      check_eq("lw_regwrite", {31'h0, wb_regwrite}, 32'h1);
      check_eq("lw_memtoreg", {31'h0, wb_memtoreg}, 32'h1);

      // SW directly after LW, ack in second request cycle: 3 stall cycles
      set_exe(0, 32'h0, 32'h100, 32'hDEAD_BEEF, 5'd0, 3'b010, 0, 1, 0, 0);
      do_access(2, 32'h0);
      check_eq("sw_stall_cycles", stall_cycles, 32'd3);
      check_eq("sw_addr", cap_addr, 32'h100);
      check_eq("sw_we", {28'h0, cap_we}, 32'hF);
      check_eq("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
      @(posedge clk);
      #1 check_eq("sw_regwrite", {31'h0, wb_regwrite}, 32'h0);

      // LB / LBU from lane 3
      set_exe(0, 32'h0, 32'h203, 32'h0, 5'd4, 3'b000, 1, 0, 1, 1);
      do_access(1, 32'h80FF_0000);
      check_eq("lb_addr", cap_addr, 32'h200);
      @(posedge clk);
      #1 check_eq("lb_lddata", wb_lddata, 32'hFFFF_FF80);
      set_exe(0, 32'h0, 32'h203, 32'h0, 5'd4, 3'b100, 1, 0, 1, 1);
      do_access(1, 32'h80FF_0000);
      @(posedge clk);
      #1 check_eq("lbu_lddata", wb_lddata, 32'h0000_0080);

      // LH / LHU from upper half
      set_exe(0, 32'h0, 32'h102, 32'h0, 5'd5, 3'b001, 1, 0, 1, 1);
      do_access(1, 32'h8001_0000);
      @(posedge clk);
      #1 check_eq("lh_lddata", wb_lddata, 32'hFFFF_8001);
      set_exe(0, 32'h0, 32'h102, 32'h0, 5'd5, 3'b101, 1, 0, 1, 1);
      do_access(1, 32'h8001_0000);
      @(posedge clk);
      #1 check_eq("lhu_lddata", wb_lddata, 32'h0000_8001);

      // SH lane 2, SB lane 1
      set_exe(0, 32'h0, 32'h302, 32'h0000_1234, 5'd0, 3'b001, 0, 1, 0, 0);
      do_access(1, 32'h0);
      check_eq("sh_addr", cap_addr, 32'h300);
      check_eq("sh_we", {28'h0, cap_we}, 32'hC);
      check_eq("sh_wdata", cap_wdata, 32'h1234_1234);
      @(posedge clk);
      #1 set_exe(0, 32'h0, 32'h101, 32'h0000_00AB, 5'd0, 3'b000, 0, 1, 0, 0);
      do_access(1, 32'h0);
      check_eq("sb_we", {28'h0, cap_we}, 32'h2);
      check_eq("sb_wdata", cap_wdata, 32'hABAB_ABAB);
      @(posedge clk);

`ifdef MEM_MISALIGN_CHK_EN
      // Misaligned LW is dropped and flagged
      #1 set_exe(0, 32'h0, 32'h102, 32'h0, 5'd6, 3'b010, 1, 0, 1, 1);
      @(negedge clk);
      check_eq("mis_no_stall", {31'h0, mem_stall}, 32'h0);
      check_eq("mis_no_req", {31'h0, dm_req}, 32'h0);
      @(posedge clk);
      #1;
      check_eq("mis_err_pulse", {31'h0, misalign_err}, 32'h1);
      check_eq("mis_regwrite", {31'h0, wb_regwrite}, 32'h0);
      check_eq("mis_no_req_after", {31'h0, dm_req}, 32'h0);
      set_exe(0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 0, 0, 0, 0);
      @(posedge clk);
      #1 check_eq("mis_err_cleared", {31'h0, misalign_err}, 32'h0);
`else
      // Misaligned SH falls back to lane 0; misaligned LW ignores low address bits
      #1 set_exe(0, 32'h0, 32'h301, 32'h0000_5678, 5'd0, 3'b001, 0, 1, 0, 0);
      do_access(1, 32'h0);
      check_eq("sh_mis_we", {28'h0, cap_we}, 32'h3);
      check_eq("sh_mis_wdata", cap_wdata, 32'h5678_5678);
      @(posedge clk);
      #1 set_exe(0, 32'h0, 32'h102, 32'h0, 5'd6, 3'b010, 1, 0, 1, 1);
      do_access(1, 32'hCAFE_F00D);
      check_eq("lw_mis_addr", cap_addr, 32'h100);
      @(posedge clk);
      #1;
      check_eq("lw_mis_lddata", wb_lddata, 32'hCAFE_F00D);
      check_eq("lw_mis_regwrite", {31'h0, wb_regwrite}, 32'h1);
      check_eq("no_misalign_err", {31'h0, misalign_err}, 32'h0);
`endif

      // Stray ack with a non-memory instruction (JAL-style rdsrc) is ignored
      set_exe(1, 32'h1004, 32'h77, 32'h0, 5'd1, 3'b000, 0, 0, 0, 1);
      dm_ack = 1'b1;
      @(negedge clk);
      check_eq("jal_forward", forward_memrddata, 32'h1004);
      check_eq("stray_ack_no_stall", {31'h0, mem_stall}, 32'h0);
      @(posedge clk);
      #1 dm_ack = 1'b0;
      check_eq("stray_ack_no_req", {31'h0, dm_req}, 32'h0);
      check_eq("jal_wb_rddata", wb_rddata, 32'h1004);

      // Reset during ACCESS abandons the transaction
      set_exe(0, 32'h0, 32'h500, 32'h0, 5'd9, 3'b010, 1, 0, 1, 1);
      @(posedge clk);
      @(negedge clk);
      check_eq("pre_rst_req", {31'h0, dm_req}, 32'h1);
      #2 rst = 1'b0;
      #1 check_eq("rst_async_req_drop", {31'h0, dm_req}, 32'h0);
      set_exe(0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 0, 0, 0, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      dm_ack   = 1'b1;
      dm_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check_eq("late_ack_no_stall", {31'h0, mem_stall}, 32'h0);
      check_eq("late_ack_no_req", {31'h0, dm_req}, 32'h0);
      @(posedge clk);
      #1 dm_ack = 1'b0;
      check_eq("late_ack_no_regwrite", {31'h0, wb_regwrite}, 32'h0);

      // Fresh access after the abandoned one behaves normally
      set_exe(0, 32'h0, 32'h600, 32'h0, 5'd2, 3'b010, 1, 0, 1, 1);
      do_access(1, 32'h0BAD_CAFE);
      check_eq("post_rst_stall_cycles", stall_cycles, 32'd2);
      @(posedge clk);
      #1;
      check_eq("post_rst_lddata", wb_lddata, 32'h0BAD_CAFE);
      check_eq("post_rst_regwrite", {31'h0, wb_regwrite}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
